// File: rtl/piano_key_conditioner.sv
// Ten-button front end: sync, debounce, last-pressed arbitration and note events.
// Produces a registered one-hot/encoded key selection with note_on/note_off pulses.
module piano_key_conditioner #(
  parameter int unsigned NUM_KEYS        = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned CNT_W           = 15,
  parameter bit          KEY_ACTIVE_LOW  = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] keys_raw,
  output logic [NUM_KEYS-1:0] key_onehot,
  output logic [3:0]          key_idx,
  output logic                key_valid,
  output logic                note_on,
  output logic                note_off
);

  typedef enum logic {IDLE, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] s1_q, s2_q, st_q, st_dly_q;
  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];

  state_t              state_q;
  logic [NUM_KEYS-1:0] onehot_q;
  logic [3:0]          idx_q;
  logic                valid_q, on_q, off_q;

  logic [NUM_KEYS-1:0] rise_other;
  logic                cur_held;
  logic [3:0]          st_sel_d, rise_sel_d;

  assign pressed = keys_raw ^ {NUM_KEYS{KEY_ACTIVE_LOW}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      st_q     <= '0;
      st_dly_q <= '0;
      for (int unsigned i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= pressed;
      s2_q     <= s1_q;
      st_dly_q <= st_q;
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (s2_q[i] == st_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_MAX) begin
          st_q[i]  <= s2_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  function automatic logic [3:0] lowest(input logic [NUM_KEYS-1:0] v);
    lowest = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (v[i-1]) lowest = 4'(i - 1);
    end
  endfunction

  // Masking with the current selection drops a (theoretical) rise on the held key.
  always_comb begin
    rise_other = st_q & ~st_dly_q & ~onehot_q;
    cur_held   = |(st_q & onehot_q);
    st_sel_d   = lowest(st_q);
    rise_sel_d = lowest(rise_other);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
    end else begin
      on_q  <= 1'b0;
      off_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|st_q) begin
            state_q  <= HOLD;
            onehot_q <= NUM_KEYS'(1) << st_sel_d;
            idx_q    <= st_sel_d;
            valid_q  <= 1'b1;
            on_q     <= 1'b1;
          end
        end
        HOLD: begin
          if (|rise_other) begin
            onehot_q <= NUM_KEYS'(1) << rise_sel_d;
            idx_q    <= rise_sel_d;
            on_q     <= 1'b1;
          end else if (!cur_held) begin
            if (|st_q) begin
              onehot_q <= NUM_KEYS'(1) << st_sel_d;
              idx_q    <= st_sel_d;
              on_q     <= 1'b1;
            end else begin
              state_q  <= IDLE;
              onehot_q <= '0;
              idx_q    <= '0;
              valid_q  <= 1'b0;
              off_q    <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign key_onehot = onehot_q;
  assign key_idx    = idx_q;
  assign key_valid  = valid_q;
  assign note_on    = on_q;
  assign note_off   = off_q;

endmodule
